// File: rtl/tree_sched_pkg.sv
// rtl/tree_sched_pkg.sv - shared state encoding and width helpers for the tree vote scheduler
package tree_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int SUM_W(int num_trees, int data_size);
        return $clog2(num_trees) + data_size;
    endfunction

    function automatic int TOTAL_W(int num_trees, int num_samples, int data_size);
        return $clog2(num_trees * num_samples) + data_size;
    endfunction

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int IDX_W(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tree_sched_reg.sv
// rtl/tree_sched_reg.sv - enabled register with synchronous active-high clear
module tree_sched_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tree_vote_scheduler_rr_arbiter.sv
// rtl/tree_vote_scheduler_rr_arbiter.sv - combinational round-robin arbiter searching upward from ptr
module rr_arbiter
    import tree_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [IDX_W(N)-1:0]   ptr,
    input  logic                  enable,
    output logic [N-1:0]          grant,
    output logic [IDX_W(N)-1:0]   grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W(N)'(idx);
            end
        end
    end

endmodule

// File: rtl/tree_vote_scheduler.sv
// rtl/tree_vote_scheduler.sv - collects one result per tree per sample, emits per-sample sums and a batch total
module tree_vote_scheduler
    import tree_sched_pkg::*;
#(
    parameter int NUM_TREES   = 4,
    parameter int NUM_SAMPLES = 2,
    parameter int DATA_SIZE   = 4
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                start,
    input  logic [NUM_TREES-1:0]                                treeValid,
    input  logic [NUM_TREES*DATA_SIZE-1:0]                      treeData,
    output logic [NUM_TREES-1:0]                                treeReady,
    output logic                                                sumValid,
    output logic [SUM_W(NUM_TREES, DATA_SIZE)-1:0]              sumData,
    output logic [IDX_W(NUM_SAMPLES)-1:0]                       sampleIdx,
    input  logic                                                sumReady,
    output logic                                                busy,
    output logic                                                batchDone,
    output logic [TOTAL_W(NUM_TREES, NUM_SAMPLES, DATA_SIZE)-1:0] batchTotal
);

    localparam int SW = SUM_W(NUM_TREES, DATA_SIZE);
    localparam int TW = TOTAL_W(NUM_TREES, NUM_SAMPLES, DATA_SIZE);
    localparam int PW = IDX_W(NUM_TREES);
    localparam int IW = IDX_W(NUM_SAMPLES);

    state_e state_q, state_d;

    logic [SW-1:0]        acc_q, acc_d;
    logic [TW-1:0]        total_q, total_d;
    logic [NUM_TREES-1:0] consumed_q, consumed_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 acc_en, total_en, consumed_en, ptr_en, idx_en;

    logic [NUM_TREES-1:0] req;
    logic [NUM_TREES-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic [DATA_SIZE-1:0] sel_data;
    logic                 accept;
    logic                 emit_hs;
    logic                 last_sample;
    logic                 in_done;

    // Already-consumed trees are masked out so a tree holding valid waits for the next sample.
    assign req = treeValid & ~consumed_q;

    rr_arbiter #(.N(NUM_TREES)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .enable    (state_q == COLLECT),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data    = treeData[int'(grant_idx)*DATA_SIZE +: DATA_SIZE];
        accept      = |(treeValid & grant);
        emit_hs     = (state_q == EMIT) && sumReady;
        last_sample = (idx_q == IW'(NUM_SAMPLES - 1));
        in_done     = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (&consumed_q) state_d = EMIT;
            EMIT:    if (sumReady) state_d = last_sample ? DONE : COLLECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_en      = accept | emit_hs;
        acc_d       = emit_hs ? '0 : acc_q + SW'(sel_data);
        consumed_en = accept | emit_hs;
        consumed_d  = emit_hs ? '0 : (consumed_q | grant);
        ptr_en      = accept;
        ptr_d       = (grant_idx == PW'(NUM_TREES - 1)) ? '0 : grant_idx + PW'(1);
        total_en    = emit_hs | in_done;
        total_d     = in_done ? '0 : total_q + TW'(acc_q);
        idx_en      = (emit_hs && !last_sample) || in_done;
        idx_d       = in_done ? '0 : idx_q + IW'(1);
    end

    tree_sched_reg #(.W(SW))        u_acc      (.clk(clk), .rst(rst), .en(acc_en),      .d(acc_d),      .q(acc_q));
    tree_sched_reg #(.W(TW))        u_total    (.clk(clk), .rst(rst), .en(total_en),    .d(total_d),    .q(total_q));
    tree_sched_reg #(.W(NUM_TREES)) u_consumed (.clk(clk), .rst(rst), .en(consumed_en), .d(consumed_d), .q(consumed_q));
    tree_sched_reg #(.W(PW))        u_ptr      (.clk(clk), .rst(rst), .en(ptr_en),      .d(ptr_d),      .q(ptr_q));
    tree_sched_reg #(.W(IW))        u_idx      (.clk(clk), .rst(rst), .en(idx_en),      .d(idx_d),      .q(idx_q));

    always_comb begin
        treeReady  = grant;
        sumValid   = (state_q == EMIT);
        sumData    = acc_q;
        sampleIdx  = idx_q;
        busy       = (state_q != IDLE);
        batchDone  = in_done;
        batchTotal = total_q;
    end

endmodule

// File: tb/tb_tree_vote_scheduler.sv
// tb/tb_tree_vote_scheduler.sv - scoreboard bench for tree_vote_scheduler
module tb_tree_vote_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  treeValid;
    logic [15:0] treeData;
    logic [3:0]  treeReady;
    logic        sumValid;
    logic [5:0]  sumData;
    logic [0:0]  sampleIdx;
    logic        sumReady;
    logic        busy;
    logic        batchDone;
    logic [6:0]  batchTotal;

    int checks = 0;
    int errors = 0;
    int q_grant[$];
    int q_sum[$];
    int q_idx[$];

    tree_vote_scheduler #(.NUM_TREES(4), .NUM_SAMPLES(2), .DATA_SIZE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .treeValid(treeValid), .treeData(treeData),
        .treeReady(treeReady), .sumValid(sumValid), .sumData(sumData), .sampleIdx(sampleIdx),
        .sumReady(sumReady), .busy(busy), .batchDone(batchDone), .batchTotal(batchTotal)
    );

    always #5 clk = ~clk;

    // Advance one cycle; handshakes seen at the falling edge are scored against the queues.
    task automatic tick();
        int e;
        int ei;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (!$onehot0(treeReady) || (sumValid && treeReady != 4'd0)) begin
                errors++;
                $display("FAIL ready_legal got %b sumValid %b", treeReady, sumValid);
            end
            if (|(treeValid & treeReady)) begin
                checks++;
                if (q_grant.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected got %b expected none", treeReady);
                end else begin
                    e = q_grant.pop_front();
                    if (treeReady !== 4'(1 << e)) begin
                        errors++;
                        $display("FAIL grant_order got %b expected tree %0d", treeReady, e);
                    end
                end
            end
            if (sumValid && sumReady) begin
                checks++;
                if (q_sum.size() == 0) begin
                    errors++;
                    $display("FAIL sum_unexpected got %0d expected none", sumData);
                end else begin
                    e  = q_sum.pop_front();
                    ei = q_idx.pop_front();
                    if (sumData !== 6'(e) || sampleIdx !== 1'(ei)) begin
                        errors++;
                        $display("FAIL sum_value got %0d/%0d expected %0d/%0d", sumData, sampleIdx, e, ei);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sum(output int cycles, output bit ok);
        cycles = 0;
        while (!sumValid && cycles < 20) begin
            tick();
            cycles++;
        end
        ok = sumValid;
    endtask

    task automatic push_grants(input int a, input int b, input int c, input int d);
        q_grant.push_back(a);
        q_grant.push_back(b);
        q_grant.push_back(c);
        q_grant.push_back(d);
    endtask

    task automatic test_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (treeReady !== 4'd0 || sumValid !== 1'b0 || busy !== 1'b0 || batchDone !== 1'b0 || sumData !== 6'd0) begin
            errors++;
            $display("FAIL reset_state got ready %b sv %b busy %b done %b sum %0d required 0", treeReady, sumValid, busy, batchDone, sumData);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sample0();
        int cyc;
        bit ok;
        push_grants(0, 1, 2, 3);
        q_sum.push_back(24);
        q_idx.push_back(0);
        treeValid = 4'hF;
        treeData  = {4'd9, 4'd7, 4'd5, 4'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || cyc != 5) begin
            errors++;
            $display("FAIL sample0_latency got %0d cycles after start cycle expected 5", cyc);
        end
        checks++;
        if (sumData !== 6'd24 || sampleIdx !== 1'b0) begin
            errors++;
            $display("FAIL sample0_sum got %0d idx %0d expected 24 idx 0", sumData, sampleIdx);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sumValid !== 1'b1 || sumData !== 6'd24 || treeReady !== 4'd0) begin
                errors++;
                $display("FAIL backpressure_hold got sv %b sum %0d ready %b expected 1 24 0000", sumValid, sumData, treeReady);
            end
        end
        push_grants(0, 1, 2, 3);
        q_sum.push_back(60);
        q_idx.push_back(1);
        sumReady = 1'b1;
        treeData = {4'd15, 4'd15, 4'd15, 4'd15};
        tick();
        sumReady = 1'b0;
    endtask

    task automatic test_sample1();
        int cyc;
        bit ok;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || sumData !== 6'd60 || sampleIdx !== 1'b1) begin
            errors++;
            $display("FAIL sample1_sum got %0d idx %0d expected 60 idx 1", sumData, sampleIdx);
        end
        sumReady  = 1'b1;
        treeValid = 4'h0;
        tick();
        sumReady = 1'b0;
        checks++;
        if (batchDone !== 1'b1 || batchTotal !== 7'd84 || busy !== 1'b1) begin
            errors++;
            $display("FAIL batch_done got done %b total %0d busy %b expected 1 84 1", batchDone, batchTotal, busy);
        end
        tick();
        checks++;
        if (batchDone !== 1'b0 || busy !== 1'b0 || batchTotal !== 7'd0 || sampleIdx !== 1'b0) begin
            errors++;
            $display("FAIL batch_end got done %b busy %b total %0d idx %0d expected 0 0 0 0", batchDone, busy, batchTotal, sampleIdx);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit ok;
        q_grant.push_back(1);
        q_grant.push_back(2);
        q_grant.push_back(3);
        q_grant.push_back(0);
        q_sum.push_back(4);
        q_idx.push_back(0);
        treeValid = 4'b1110;
        treeData  = {4'd1, 4'd1, 4'd1, 4'd1};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        treeValid = 4'b0001;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || sumData !== 6'd4) begin
            errors++;
            $display("FAIL rr_sampleA got %0d expected 4", sumData);
        end
        q_grant.push_back(2);
        q_grant.push_back(0);
        sumReady  = 1'b1;
        treeValid = 4'b0101;
        treeData  = {4'd8, 4'd4, 4'd8, 4'd2};
        tick();
        sumReady = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (treeReady !== 4'd0) begin
                errors++;
                $display("FAIL rr_no_regrant got %b expected 0000", treeReady);
            end
        end
        q_grant.push_back(1);
        q_grant.push_back(3);
        q_sum.push_back(22);
        q_idx.push_back(1);
        treeValid = 4'hF;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || sumData !== 6'd22) begin
            errors++;
            $display("FAIL rr_sampleB got %0d expected 22", sumData);
        end
        sumReady  = 1'b1;
        treeValid = 4'h0;
        tick();
        sumReady = 1'b0;
        checks++;
        if (batchDone !== 1'b1 || batchTotal !== 7'd26) begin
            errors++;
            $display("FAIL rr_total got done %b total %0d expected 1 26", batchDone, batchTotal);
        end
        tick();
    endtask

    task automatic test_abort();
        int cyc;
        bit ok;
        q_grant.push_back(0);
        q_grant.push_back(1);
        treeValid = 4'hF;
        treeData  = {4'd9, 4'd7, 4'd5, 4'd3};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        treeValid = 4'h0;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || sumData !== 6'd0 || treeReady !== 4'd0 || sumValid !== 1'b0 || batchDone !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got busy %b acc %0d ready %b sv %b done %b expected 0", busy, sumData, treeReady, sumValid, batchDone);
        end
        push_grants(0, 1, 2, 3);
        q_sum.push_back(24);
        q_idx.push_back(0);
        treeValid = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || sumData !== 6'd24) begin
            errors++;
            $display("FAIL abort_restart got %0d expected 24", sumData);
        end
        push_grants(0, 1, 2, 3);
        q_sum.push_back(60);
        q_idx.push_back(1);
        sumReady = 1'b1;
        treeData = {4'd15, 4'd15, 4'd15, 4'd15};
        tick();
        sumReady = 1'b0;
        wait_sum(cyc, ok);
        checks++;
        if (!ok || sumData !== 6'd60) begin
            errors++;
            $display("FAIL abort_sample1 got %0d expected 60", sumData);
        end
        sumReady  = 1'b1;
        treeValid = 4'h0;
        tick();
        sumReady = 1'b0;
        checks++;
        if (batchDone !== 1'b1 || batchTotal !== 7'd84) begin
            errors++;
            $display("FAIL abort_total got done %b total %0d expected 1 84", batchDone, batchTotal);
        end
        tick();
    endtask

    task automatic test_drain();
        checks++;
        if (q_grant.size() != 0 || q_sum.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d grants %0d sums pending expected 0 0", q_grant.size(), q_sum.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        treeValid = 4'h0;
        treeData  = 16'h0;
        sumReady  = 1'b0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_sample0();
        test_backpressure();
        test_sample1();
        test_round_robin();
        test_abort();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tree_vote_scheduler.md
Name: tree_vote_scheduler

Overview:
- Sequences result collection from NUM_TREES parallel tree evaluators into one shared accumulator.
- Arbitrates the evaluators round-robin with valid/ready handshakes and accepts exactly one result per tree per sample.
- For each sample, emits the per-sample sum over a valid/ready output, then returns the batch total after NUM_SAMPLES samples.
- Sits between the tree evaluator array and the downstream classification/threshold logic.

Parameters:
NUM_TREES, 4, number of tree evaluators; must be ≥2
NUM_SAMPLES, 2, samples per batch; must be ≥1
DATA_SIZE, 4, width of one tree result (unsigned)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin batch; sampled only in IDLE
treeValid  input  NUM_TREES  per-tree result valid
treeData  input  NUM_TREES*DATA_SIZE  tree t result at bits [t*DATA_SIZE +: DATA_SIZE]
treeReady  output  NUM_TREES  one-hot grant; at most one bit high
sumValid  output  1  per-sample sum valid
sumData  output  $clog2(NUM_TREES)+DATA_SIZE  per-sample sum
sampleIdx  output  max(1,$clog2(NUM_SAMPLES))  index of current sample
sumReady  input  1  downstream accepts sum
busy  output  1  high whenever state != IDLE
batchDone  output  1  one-cycle pulse at batch end
batchTotal  output  $clog2(NUM_TREES*NUM_SAMPLES)+DATA_SIZE  sum of all samples; valid while batchDone is high

Behaviour:
- Reset is synchronous. State goes to IDLE; accumulator, batchTotal, consumed mask, rrPtr and sampleIdx go to 0; treeReady, sumValid and batchDone go to 0.
- FSM states: IDLE, COLLECT, EMIT, DONE.
- IDLE -> COLLECT when start=1. While in IDLE, treeReady=0.
- COLLECT grant (combinational): the first tree t, searching from rrPtr upward modulo NUM_TREES, with treeValid[t]=1 and consumed[t]=0.
  - treeReady has only bit t high. If no tree qualifies, treeReady=0.
- COLLECT accept, on a cycle where treeValid[t] & treeReady[t]:
  - acc += treeData[t]
  - consumed[t] <= 1
  - rrPtr <= (t+1) mod NUM_TREES
  - Latency is one accept per cycle at most.
- COLLECT -> EMIT on the cycle after consumed becomes all-ones; that is, the final accept's registered update triggers the transition.
- EMIT:
  - sumValid=1, sumData=acc, treeReady=0.
  - sumValid and sumData hold stable until sumReady=1.
- On the EMIT handshake:
  - batchTotal += acc; acc <= 0; consumed <= 0.
  - If sampleIdx==NUM_SAMPLES-1, go to DONE. Otherwise sampleIdx++ and go to COLLECT.
- DONE: batchDone=1 for exactly one cycle with batchTotal stable.
  - Next cycle: IDLE, sampleIdx <= 0, batchTotal <= 0.
- Widths: acc is zero-extended on add. Maximum per-sample value NUM_TREES*(2^DATA_SIZE-1) fits sumData, so there is no overflow and no saturation.
- A tree whose result was already consumed for the current sample is not granted, even if treeValid stays high. It waits for the next sample.
- start asserted outside IDLE is ignored.
- sumReady outside EMIT is ignored.
- rst mid-operation aborts the batch with no sumValid or batchDone.
- treeData of a non-granted tree must not affect any state.

Decomposition:
- Package tree_sched_pkg:
  - state enum {IDLE, COLLECT, EMIT, DONE}
  - localparam width functions SUM_W(NUM_TREES, DATA_SIZE) and TOTAL_W(NUM_TREES, NUM_SAMPLES, DATA_SIZE)
- Sub-module rr_arbiter #(N):
  - Inputs: req (= treeValid & ~consumed), ptr, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational.
- Counters and accumulator use the existing register module with enables.

Test Plan (defaults 4/2/4):
- Reset: hold rst 2 cycles in mid-stream -> treeReady=0, sumValid=0, busy=0, batchDone=0, sumData=0.
- Sample 0, all treeValid=1, data 3,5,7,9 -> accepts trees 0,1,2,3 on 4 consecutive cycles; sumValid with sumData=24 and sampleIdx=0.
- Backpressure: hold sumReady=0 for 3 cycles in EMIT -> sumValid stays 1, sumData stays 24, treeReady=0 throughout; accept on cycle 4.
- Sample 1, all trees data 15 -> sumData=60, sampleIdx=1; after the handshake, batchDone pulses 1 cycle with batchTotal=84, then busy=0.
- Round-robin: rrPtr=1 with only trees 0 and 2 valid -> tree 2 granted first, then tree 0. A tree held valid after being consumed is not re-granted before EMIT.
- Abort: assert rst after 2 accepts in COLLECT -> next cycle IDLE with acc=0; a new start then yields the correct sum 24 for the sample-0 stimulus.
